// File: rtl/trans_sched.sv
// Transfer sequencer for the 8-port, two-lane crossbar: one burst FSM per lane
// driving isel, with osel trailing by one cycle to match the crossbar fan stage.
module trans_sched_lane (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] src_i,
    input  logic [7:0] dst_i,
    input  logic [7:0] len_i,
    output logic [7:0] isel_o,
    output logic [7:0] omask_d_o,
    output logic [7:0] dst_active_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dst_q, dst_d;
    logic [2:0] src_q, src_d;
    logic [7:0] isel_q, isel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    cnt_d   = len_i;
                    src_d   = src_i;
                    dst_d   = dst_i;
                end
            end
            FETCH: begin
                if (cnt_q == 8'd0) state_d = DRAIN;
                else               cnt_d   = cnt_q - 8'd1;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        isel_d = (state_d == FETCH) ? (8'd1 << src_d) : 8'd0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DRAIN);
        // Every FETCH cycle's word gets its osel one cycle later.
        omask_d_o = (state_q == FETCH && !rst_i) ? dst_q : 8'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            src_q   <= 3'd0;
            dst_q   <= 8'd0;
            isel_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            isel_q  <= isel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The mask stays claimed through the lane's final osel (DRAIN) cycle.
    assign dst_active_o = busy_q ? dst_q : 8'd0;
    assign isel_o       = isel_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

module trans_sched (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_lane,
    input  logic [2:0]  req_src,
    input  logic [7:0]  req_dst,
    input  logic [7:0]  req_len,
    output logic [15:0] isel,
    output logic [15:0] osel,
    output logic [1:0]  busy,
    output logic [1:0]  done
);
    logic [1:0][7:0] isel_l;
    logic [1:0][7:0] omask_d;
    logic [1:0][7:0] dst_act;
    logic [1:0]      start;
    logic [15:0]     osel_q, osel_d;

    assign req_ready = ~busy[req_lane] & ~RST & ((req_dst & dst_act[~req_lane]) == 8'd0);

    for (genvar l = 0; l < 2; l++) begin : g_lane
        assign start[l] = req_valid & req_ready & (req_lane == 1'(l));
        trans_sched_lane u_lane (
            .clk_i        (CLK),
            .rst_i        (RST),
            .start_i      (start[l]),
            .src_i        (req_src),
            .dst_i        (req_dst),
            .len_i        (req_len),
            .isel_o       (isel_l[l]),
            .omask_d_o    (omask_d[l]),
            .dst_active_o (dst_act[l]),
            .busy_o       (busy[l]),
            .done_o       (done[l])
        );
    end

    // Upper byte is the port mux: 1 selects lane 0, so only lane 0 drives it.
    assign osel_d = {omask_d[0], omask_d[0] | omask_d[1]};

    always_ff @(posedge CLK) begin
        if (RST) osel_q <= 16'd0;
        else     osel_q <= osel_d;
    end

    assign isel = isel_l;
    assign osel = osel_q;
endmodule

// File: tb/tb_trans_sched.sv
// Randomized and directed bench for trans_sched against a timeline model:
// each accepted burst is kept as (accept edge, len, src, dst) per lane.
module tb_trans_sched;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_lane = 1'b0;
    logic [2:0]  req_src = 3'd0;
    logic [7:0]  req_dst = 8'd0;
    logic [7:0]  req_len = 8'd0;
    logic [15:0] isel, osel;
    logic [1:0]  busy, done;

    always #5 CLK = ~CLK;

    trans_sched dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_lane(req_lane), .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
        .isel(isel), .osel(osel), .busy(busy), .done(done)
    );

    int n_chk = 0;
    int n_pass = 0;
    int edge_n = 0;
    bit m_act [2];
    int m_t   [2];
    int m_len [2];
    int m_src [2];
    logic [7:0] m_dst [2];
    bit last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    // A burst accepted at edge T occupies the lane for samples T..T+len+1.
    function automatic bit lane_busy(input int l);
        return m_act[l] && ((edge_n - m_t[l]) <= m_len[l] + 1);
    endfunction

    function automatic logic model_ready();
        int me, other;
        me    = int'(req_lane);
        other = 1 - me;
        if (RST) return 1'b0;
        if (lane_busy(me)) return 1'b0;
        if (lane_busy(other) && ((m_dst[other] & req_dst) != 8'd0)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic [15:0] ei, eo;
        logic [1:0]  eb, ed;
        int d;
        ei = '0; eo = '0; eb = '0; ed = '0;
        for (int l = 0; l < 2; l++) begin
            if (m_act[l]) begin
                d = edge_n - m_t[l];
                if (d <= m_len[l]) ei[l*8 +: 8] = 8'(1 << m_src[l]);
                if (d >= 1 && d <= m_len[l] + 1) begin
                    eo[7:0] = eo[7:0] | m_dst[l];
                    if (l == 0) eo[15:8] = eo[15:8] | m_dst[l];
                end
                eb[l] = (d <= m_len[l] + 1);
                ed[l] = (d == m_len[l] + 1);
            end
        end
        chk("isel", {16'd0, isel}, {16'd0, ei});
        chk("osel", {16'd0, osel}, {16'd0, eo});
        chk("busy", {30'd0, busy}, {30'd0, eb});
        chk("done", {30'd0, done}, {30'd0, ed});
    endtask

    task automatic step();
        logic er;
        #1;
        er = model_ready();
        chk("req_ready", {31'd0, req_ready}, {31'd0, er});
        @(posedge CLK);
        edge_n++;
        last_acc = 1'b0;
        if (RST) begin
            m_act[0] = 1'b0;
            m_act[1] = 1'b0;
        end else if (req_valid && er) begin
            m_act[req_lane] = 1'b1;
            m_t[req_lane]   = edge_n;
            m_len[req_lane] = int'(req_len);
            m_src[req_lane] = int'(req_src);
            m_dst[req_lane] = req_dst;
            last_acc = 1'b1;
        end
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic req(input logic l, input logic [2:0] s, input logic [7:0] dm, input logic [7:0] n);
        req_valid = 1'b1; req_lane = l; req_src = s; req_dst = dm; req_len = n;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    int t0, cnt_i, cnt_o, cnt_d, cnt_r;
    bit got;

    initial begin
        m_act[0] = 1'b0; m_act[1] = 1'b0;
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        idle(1);

        // single burst
        req(1'b0, 3'd3, 8'h05, 8'd2); step();
        chk("sb_isel", {16'd0, isel}, 32'h0008);
        req_valid = 1'b0; step();
        chk("sb_osel", {16'd0, osel}, 32'h0505);
        step(); step();
        chk("sb_done", {30'd0, done}, 32'h1);
        chk("sb_osel_last", {16'd0, osel}, 32'h0505);
        step();
        chk("sb_quiet", {31'd0, |{isel, osel, busy, done}}, 32'h0);

        // lane 1 mux polarity
        req(1'b1, 3'd7, 8'h80, 8'd0); step();
        chk("l1_isel", {16'd0, isel}, 32'h8000);
        req_valid = 1'b0; step();
        chk("l1_osel", {16'd0, osel}, 32'h0080);
        chk("l1_done", {30'd0, done}, 32'h2);
        idle(2);

        // destination conflict
        req(1'b0, 3'd0, 8'h0F, 8'd4); step();
        t0 = edge_n;
        req(1'b1, 3'd1, 8'h18, 8'd0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = last_acc;
        end
        chk("cf_accepted", {31'd0, got}, 32'h1);
        chk("cf_wait", 32'(edge_n - t0), 32'd7);
        idle(4);

        // concurrent lanes sharing a source
        req(1'b0, 3'd2, 8'h01, 8'd3); step();
        req(1'b1, 3'd2, 8'h02, 8'd3); step();
        chk("cc_isel", {16'd0, isel}, 32'h0404);
        chk("cc_osel0", {16'd0, osel}, 32'h0101);
        req_valid = 1'b0; step();
        chk("cc_osel1", {16'd0, osel}, 32'h0103);
        idle(6);

        // reset mid-burst
        req(1'b0, 3'd1, 8'hF0, 8'd10); step();
        idle(4);
        RST = 1'b1; step();
        chk("rst_quiet", {31'd0, |{isel, osel, busy, done}}, 32'h0);
        RST = 1'b0;
        req(1'b0, 3'd5, 8'h0C, 8'd1); step();
        chk("rst_reacc", {31'd0, last_acc}, 32'h1);
        idle(5);

        // max length, lane 0 request held throughout
        req(1'b0, 3'd4, 8'h30, 8'd255); step();
        cnt_i = 0; cnt_o = 0; cnt_d = 0; cnt_r = 0;
        for (int i = 0; i < 262; i++) begin
            if (isel[7:0] != 8'd0) cnt_i++;
            if (osel[7:0] != 8'd0) cnt_o++;
            if (done[0]) cnt_d++;
            if (i < 256 && req_ready) cnt_r++;
            if (i == 256) req_valid = 1'b0;
            step();
        end
        chk("ml_isel_cycles", 32'(cnt_i), 32'd256);
        chk("ml_osel_cycles", 32'(cnt_o), 32'd256);
        chk("ml_done_pulses", 32'(cnt_d), 32'd1);
        chk("ml_ready_low", 32'(cnt_r), 32'd0);
        idle(3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_lane  = 1'($urandom_range(0, 1));
            req_src   = 3'($urandom_range(0, 7));
            req_dst   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom & $urandom);
            req_len   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 5));
            RST       = ($urandom_range(0, 99) == 0);
            step();
        end
        RST = 1'b0;
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/trans_sched.md
# trans_sched

Transfer sequencer that drives the select inputs of the 8-port, two-lane hyperfabric crossbar. It accepts burst requests of the form "source port, destination mask, lane, length" and generates cycle-exact `isel`/`osel` patterns, including the one-cycle offset imposed by the crossbar's registered fan stage. It enforces destination exclusivity between the two lanes and reports completion per lane.

## Interface
Parameters:
- none; port count (8) and lane count (2) are fixed by the crossbar.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: synchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on `req_valid & req_ready` at posedge (combinational).
- `req_lane` in 1: lane index, 0 or 1.
- `req_src` in 3: source port index, 0..7.
- `req_dst` in 8: destination port mask.
- `req_len` in 8: burst length minus one, giving 1..256 words.
- `isel` out 16: registered. `isel[7:0]` is a one-hot source for lane 0; `isel[15:8]` is a one-hot source for lane 1.
- `osel` out 16: registered. `osel[7:0]` is the per-port write enable; `osel[15:8]` is the per-port mux, 1 = lane 0, 0 = lane 1.
- `busy` out 2: registered, per-lane active.
- `done` out 2: registered, per-lane one-cycle completion pulse.

## Operation
- **Lane FSM (per lane):** IDLE → FETCH → DRAIN → IDLE.
  - IDLE: outputs for the lane are zero.
  - FETCH: the lane's `isel` byte is `1 << src`, and the word counter counts down from `len`.
  - DRAIN: the last output cycle, with `isel` for the lane at zero.
  - In FETCH, each cycle after the first also drives `osel` for the previous word.
- **Acceptance.** `req_ready = ~busy[req_lane] & ~RST & ((req_dst & dst_active[~req_lane]) == 0)`.
  - `dst_active[l]` holds lane l's latched mask from acceptance until its last `osel` cycle, inclusive.
- **Outputs.**
  - For lane 0, `osel[p]` and `osel[8+p]` are set for each p in `dst_0`.
  - For lane 1, only `osel[p]` is set; `osel[8+p]` = 0.
  - Ports outside both active masks have `osel[p]` = 0 and `osel[8+p]` = 0.
- **Lane overlap.** Both lanes may run simultaneously and may share a source; their `isel` bytes are independent. Destination masks never overlap, so `osel` bits never conflict.
- **Zero mask.** `req_dst == 0` is legal: `isel` runs and `done` pulses, but no `osel` bit asserts.
- **Counter width.** The counter is 8 bits, so `len` = 255 yields 256 words. The counter is not reloaded mid-burst; `req_*` is ignored while the lane is busy.
- **Reset.** `RST` asserted in any cycle: next edge forces all FSMs to IDLE, and `isel`, `osel`, `busy`, `done` and `dst_active` to 0. An in-flight burst is abandoned and produces no `done`.

## Timing
- Request accepted at edge T:
  - `busy[l]` = 1 from T+1.
  - The lane's `isel` bit is high in cycles T+1..T+1+len.
  - The lane's `osel` bits are high in cycles T+2..T+2+len.
  - `done[l]` pulses in cycle T+2+len, coincident with the last `osel`.
  - `busy[l]` falls at T+3+len.
- Word k sent via `isel` in cycle c appears on the crossbar output register at the end of cycle c+1.
- The earliest next acceptance on the same lane is edge T+3+len, so there is a minimum one-cycle gap between bursts on a lane.
- Destination release: the other lane may claim those ports at edge T+3+len, because `dst_active` clears after the last `osel` cycle.
- Simultaneous events:
  - Only one request can be presented per cycle.
  - `done` on one lane and acceptance on the other lane in the same cycle are independent.
  - `done` on a lane and a request to the same lane in that cycle: not ready.

## Test plan
- **Single burst.** After reset, request lane 0, src=3, dst=0x05, len=2 at T.
  - `isel` = 0x0008 in T+1..T+3.
  - `osel` = 0x0505 in T+2..T+4.
  - `done` = 01 at T+4.
  - All outputs zero from T+5.
- **Lane 1 mux polarity.** Request lane 1, src=7, dst=0x80, len=0.
  - `isel` = 0x8000 for one cycle.
  - `osel` = 0x0080 for one cycle.
  - `done` = 10 in that cycle.
- **Conflict.** Lane 0 active with dst=0x0F; present lane 1 with dst=0x18.
  - `req_ready` = 0 until lane 0's last `osel` cycle has passed.
  - Accepted on the next edge.
  - Lane 1 `osel` never overlaps lane 0's.
- **Concurrent lanes sharing a source.**
  - Lane 0: src=2, dst=0x01, len=3. Lane 1: src=2, dst=0x02, len=3, one cycle later.
  - `isel` shows 0x0004 and 0x0400 overlapping.
  - `osel` shows 0x0101 then 0x0103 during overlap.
- **Reset mid-burst.** Lane 0, len=10; assert `RST` for one cycle at word 4.
  - The next cycle has all outputs 0 and no `done`.
  - A new request is accepted on the edge after `RST` deasserts.
- **Max length.** Lane 0, len=255.
  - Exactly 256 `isel` cycles and 256 `osel` cycles.
  - A single `done` pulse.
  - `req_ready` for lane 0 stays low throughout.
